// File: rtl/ghost_move_scheduler.sv
// Time-multiplexes one shared ghost controller across NUM_GHOSTS ghosts, one pass per game tick.
// Optional feature macro: GHOST_FREEZE_EN (adds freeze_mask; frozen ghosts are skipped).
//
// state     | meaning
// S_IDLE    | waiting for tick; loads accepted here only
// S_PRESENT | drive ghost idx onto ctrl_* (or skip a frozen ghost)
// S_WAIT    | hold ctrl_* stable while the controller computes
// S_APPLY   | capture ctrl_dir, move ghost idx, advance idx
// S_DONE    | one-cycle frame_done pulse
module ghost_move_scheduler #(
   parameter int NUM_GHOSTS = 4,
   parameter int STEP       = 1,
   parameter int CTRL_LAT   = 2,
   parameter int X_W        = 11,
   parameter int Y_W        = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    tick,
   input  logic [X_W-1:0]          pacman_x,
   input  logic [Y_W-1:0]          pacman_y,
   input  logic                    load,
   input  logic [2:0]              load_idx,
   input  logic [X_W-1:0]          load_x,
   input  logic [Y_W-1:0]          load_y,
`ifdef GHOST_FREEZE_EN
   input  logic [NUM_GHOSTS-1:0]   freeze_mask,
`endif
   output logic [X_W-1:0]          ctrl_ghost_x,
   output logic [Y_W-1:0]          ctrl_ghost_y,
   output logic [X_W-1:0]          ctrl_pac_x,
   output logic [Y_W-1:0]          ctrl_pac_y,
   output logic [3:0]              ctrl_prev_dir,
   input  logic [3:0]              ctrl_dir,
   output logic [NUM_GHOSTS*X_W-1:0] ghost_x_flat,
   output logic [NUM_GHOSTS*Y_W-1:0] ghost_y_flat,
   output logic [NUM_GHOSTS*4-1:0]   ghost_dir_flat,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    overrun
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_PRESENT = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_APPLY   = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   localparam int IDX_W = (NUM_GHOSTS > 1) ? $clog2(NUM_GHOSTS) : 1;
   localparam int CNT_W = (CTRL_LAT > 1) ? $clog2(CTRL_LAT) : 1;

   logic [2:0]       r_state;
   logic [IDX_W-1:0] r_idx;
   logic [CNT_W-1:0] r_cnt;
   logic [X_W-1:0]   r_gx [NUM_GHOSTS];
   logic [Y_W-1:0]   r_gy [NUM_GHOSTS];
   logic [3:0]       r_gd [NUM_GHOSTS];
   logic [X_W-1:0]   r_ctrl_gx, r_ctrl_px;
   logic [Y_W-1:0]   r_ctrl_gy, r_ctrl_py;
   logic [3:0]       r_ctrl_pd;
   logic             r_ovr;

   logic             w_frozen, w_last, w_load_ok, w_onehot;
   logic [IDX_W-1:0] w_lidx;
   logic [X_W:0]     w_xsum, w_xdif;
   logic [Y_W:0]     w_ysum, w_ydif;
   logic [X_W-1:0]   w_nx;
   logic [Y_W-1:0]   w_ny;

`ifdef GHOST_FREEZE_EN
   logic [NUM_GHOSTS-1:0] r_freeze;
   assign w_frozen = r_freeze[r_idx];
`else
   assign w_frozen = 1'b0;
`endif

   assign w_last    = (r_idx == IDX_W'(NUM_GHOSTS - 1));
   assign w_load_ok = ({1'b0, load_idx} < 4'(NUM_GHOSTS));
   assign w_lidx    = load_idx[IDX_W-1:0];
   assign w_onehot  = (ctrl_dir == 4'b0001) || (ctrl_dir == 4'b0010) ||
                      (ctrl_dir == 4'b0100) || (ctrl_dir == 4'b1000);

   // One extra bit catches carry/borrow so moves clamp at the screen edges instead of wrapping.
   assign w_xsum = {1'b0, r_ctrl_gx} + (X_W+1)'(STEP);
   assign w_xdif = {1'b0, r_ctrl_gx} - (X_W+1)'(STEP);
   assign w_ysum = {1'b0, r_ctrl_gy} + (Y_W+1)'(STEP);
   assign w_ydif = {1'b0, r_ctrl_gy} - (Y_W+1)'(STEP);

   always_comb begin
      w_nx = r_ctrl_gx;
      w_ny = r_ctrl_gy;
      case (ctrl_dir)
         4'b0001: w_nx = w_xsum[X_W] ? '1 : w_xsum[X_W-1:0];
         4'b1000: w_nx = w_xdif[X_W] ? '0 : w_xdif[X_W-1:0];
         4'b0100: w_ny = w_ysum[Y_W] ? '1 : w_ysum[Y_W-1:0];
         4'b0010: w_ny = w_ydif[Y_W] ? '0 : w_ydif[Y_W-1:0];
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_idx     <= '0;
         r_cnt     <= '0;
         r_ctrl_gx <= '0;
         r_ctrl_gy <= '0;
         r_ctrl_px <= '0;
         r_ctrl_py <= '0;
         r_ctrl_pd <= '0;
         r_ovr     <= 1'b0;
`ifdef GHOST_FREEZE_EN
         r_freeze  <= '0;
`endif
         for (int i = 0; i < NUM_GHOSTS; i++) begin
            r_gx[i] <= '0;
            r_gy[i] <= '0;
            r_gd[i] <= '0;
         end
      end else begin
         if (tick && (r_state != S_IDLE))
            r_ovr <= 1'b1;
         case (r_state)
            S_IDLE: begin
               // Load is written before PRESENT reads the array, so a same-cycle tick sees it.
               if (load && w_load_ok) begin
                  r_gx[w_lidx] <= load_x;
                  r_gy[w_lidx] <= load_y;
               end
               if (tick) begin
                  r_ctrl_px <= pacman_x;
                  r_ctrl_py <= pacman_y;
                  r_idx     <= '0;
`ifdef GHOST_FREEZE_EN
                  r_freeze  <= freeze_mask;
`endif
                  r_state   <= S_PRESENT;
               end
            end
            S_PRESENT: begin
               if (w_frozen) begin
                  r_idx   <= w_last ? r_idx : r_idx + 1'b1;
                  r_state <= w_last ? S_DONE : S_PRESENT;
               end else begin
                  r_ctrl_gx <= r_gx[r_idx];
                  r_ctrl_gy <= r_gy[r_idx];
                  r_ctrl_pd <= r_gd[r_idx];
                  r_cnt     <= CNT_W'(CTRL_LAT - 1);
                  r_state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == '0)
                  r_state <= S_APPLY;
               else
                  r_cnt <= r_cnt - 1'b1;
            end
            S_APPLY: begin
               if (w_onehot) begin
                  r_gx[r_idx] <= w_nx;
                  r_gy[r_idx] <= w_ny;
                  r_gd[r_idx] <= ctrl_dir;
               end
               r_idx   <= w_last ? r_idx : r_idx + 1'b1;
               r_state <= w_last ? S_DONE : S_PRESENT;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   generate
      for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_flat
         assign ghost_x_flat[g*X_W +: X_W] = r_gx[g];
         assign ghost_y_flat[g*Y_W +: Y_W] = r_gy[g];
         assign ghost_dir_flat[g*4 +: 4]   = r_gd[g];
      end
   endgenerate

   assign ctrl_ghost_x  = r_ctrl_gx;
   assign ctrl_ghost_y  = r_ctrl_gy;
   assign ctrl_pac_x    = r_ctrl_px;
   assign ctrl_pac_y    = r_ctrl_py;
   assign ctrl_prev_dir = r_ctrl_pd;
   assign busy          = (r_state != S_IDLE);
   assign frame_done    = (r_state == S_DONE);
   assign overrun       = r_ovr;

endmodule

// File: tb/tb_ghost_move_scheduler.sv
// Scoreboard bench for ghost_move_scheduler: frames push expected ghost state, a monitor checks at frame_done.
module tb_ghost_move_scheduler;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick = 1'b0;
   logic        load = 1'b0;
   logic [2:0]  load_idx = '0;
   logic [10:0] load_x = '0, pacman_x = '0;
   logic [9:0]  load_y = '0, pacman_y = '0;
   logic [3:0]  ctrl_dir = '0;
   logic [10:0] ctrl_ghost_x, ctrl_pac_x;
   logic [9:0]  ctrl_ghost_y, ctrl_pac_y;
   logic [3:0]  ctrl_prev_dir;
   logic [43:0] ghost_x_flat;
   logic [39:0] ghost_y_flat;
   logic [15:0] ghost_dir_flat;
   logic        busy, frame_done, overrun;
`ifdef GHOST_FREEZE_EN
   logic [3:0]  freeze_mask = '0;
   bit          saw_frozen = 1'b0;
`endif

   ghost_move_scheduler dut (
      .clk(clk), .rst_n(rst_n), .tick(tick),
      .pacman_x(pacman_x), .pacman_y(pacman_y),
      .load(load), .load_idx(load_idx), .load_x(load_x), .load_y(load_y),
`ifdef GHOST_FREEZE_EN
      .freeze_mask(freeze_mask),
`endif
      .ctrl_ghost_x(ctrl_ghost_x), .ctrl_ghost_y(ctrl_ghost_y),
      .ctrl_pac_x(ctrl_pac_x), .ctrl_pac_y(ctrl_pac_y),
      .ctrl_prev_dir(ctrl_prev_dir), .ctrl_dir(ctrl_dir),
      .ghost_x_flat(ghost_x_flat), .ghost_y_flat(ghost_y_flat),
      .ghost_dir_flat(ghost_dir_flat),
      .busy(busy), .frame_done(frame_done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [43:0] x;
      logic [39:0] y;
      logic [15:0] d;
      int          t0;
      int          lat;
      logic        ovr;
   } exp_t;
   exp_t q[$];

   logic [10:0] ex [4];
   logic [9:0]  ey [4];
   logic [3:0]  ed [4];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   task automatic set_g(input int i, input int x, input int y, input logic [3:0] d);
      ex[i] = 11'(x);
      ey[i] = 10'(y);
      ed[i] = d;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && frame_done) begin
         if (q.size() == 0) begin
            chk("spurious_frame_done", 64'(q.size()), 64'd1);
         end else begin
            e = q.pop_front();
            chk("ghost_x_flat", 64'(ghost_x_flat), 64'(e.x));
            chk("ghost_y_flat", 64'(ghost_y_flat), 64'(e.y));
            chk("ghost_dir_flat", 64'(ghost_dir_flat), 64'(e.d));
            chk("frame_latency", 64'(cyc - e.t0), 64'(e.lat));
            chk("overrun_at_done", 64'(overrun), 64'(e.ovr));
         end
      end
`ifdef GHOST_FREEZE_EN
      if (busy && (ctrl_ghost_x == 11'd10 || ctrl_ghost_x == 11'd30)) saw_frozen = 1'b1;
`endif
   end

   task automatic do_load(input int idx, input int x, input int y);
      @(negedge clk);
      load = 1'b1; load_idx = 3'(idx); load_x = 11'(x); load_y = 10'(y);
      @(negedge clk);
      load = 1'b0;
   endtask

   // Runs one frame; ex/ey/ed hold the hand-computed result. ovr_at>0 fires a second tick and a load mid-frame.
   task automatic run_frame(input logic [3:0] dir, input int lat, input logic exp_ovr,
                            input bit with_load, input int lidx, input int lx, input int ly,
                            input int ovr_at);
      exp_t e;
      bit   seen;
      int   t0;
      @(negedge clk);
      ctrl_dir = dir;
      tick = 1'b1;
      if (with_load) begin
         load = 1'b1; load_idx = 3'(lidx); load_x = 11'(lx); load_y = 10'(ly);
      end
      t0 = cyc;
      e.x = {ex[3], ex[2], ex[1], ex[0]};
      e.y = {ey[3], ey[2], ey[1], ey[0]};
      e.d = {ed[3], ed[2], ed[1], ed[0]};
      e.t0 = t0; e.lat = lat; e.ovr = exp_ovr;
      q.push_back(e);
      @(negedge clk);
      tick = 1'b0; load = 1'b0;
      chk("busy_after_tick", 64'(busy), 64'd1);
      seen = 1'b0;
      for (int n = 0; n < 60 && !seen; n++) begin
         tick = (ovr_at > 0) && (cyc == t0 + ovr_at);
         load = tick; load_idx = 3'd2; load_x = 11'd500; load_y = 10'd500;
         @(negedge clk);
         if (frame_done) seen = 1'b1;
      end
      tick = 1'b0; load = 1'b0;
      if (!seen) begin
         chk("frame_timeout", 64'(frame_done), 64'd1);
         q.delete();
      end
      @(negedge clk);
      chk("busy_after_done", 64'(busy), 64'd0);
   endtask

   initial begin
      #23 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_x_flat", 64'(ghost_x_flat), 64'd0);
      chk("rst_dir_flat", 64'(ghost_dir_flat), 64'd0);
      chk("rst_busy", 64'({busy, frame_done, overrun}), 64'd0);
      chk("rst_ctrl", 64'({ctrl_ghost_x, ctrl_pac_y, ctrl_prev_dir}), 64'd0);

      do_load(1, 100, 50);
      do_load(5, 7, 7);
      chk("load_idx_oob_ignored", 64'(ghost_x_flat[21:11]), 64'd100);

      pacman_x = 11'd300; pacman_y = 10'd200;
      set_g(0, 1, 0, 4'b0001); set_g(1, 101, 50, 4'b0001);
      set_g(2, 1, 0, 4'b0001); set_g(3, 1, 0, 4'b0001);
      run_frame(4'b0001, 17, 1'b0, 0, 0, 0, 0, 0);
      chk("pac_snapshot_x", 64'(ctrl_pac_x), 64'd300);
      chk("pac_snapshot_y", 64'(ctrl_pac_y), 64'd200);

      do_load(0, 0, 0);
      set_g(0, 0, 0, 4'b1000); set_g(1, 100, 50, 4'b1000);
      set_g(2, 0, 0, 4'b1000); set_g(3, 0, 0, 4'b1000);
      run_frame(4'b1000, 17, 1'b0, 0, 0, 0, 0, 0);

      set_g(0, 0, 0, 4'b0010); set_g(1, 100, 49, 4'b0010);
      set_g(2, 0, 0, 4'b0010); set_g(3, 0, 0, 4'b0010);
      run_frame(4'b0010, 17, 1'b0, 0, 0, 0, 0, 0);
      run_frame(4'b0000, 17, 1'b0, 0, 0, 0, 0, 0);
      run_frame(4'b0011, 17, 1'b0, 0, 0, 0, 0, 0);

      set_g(0, 1, 0, 4'b0001); set_g(1, 101, 49, 4'b0001);
      set_g(2, 1, 0, 4'b0001); set_g(3, 2047, 1023, 4'b0001);
      run_frame(4'b0001, 17, 1'b0, 1, 3, 2047, 1023, 0);

      set_g(0, 1, 1, 4'b0100); set_g(1, 101, 50, 4'b0100);
      set_g(2, 1, 1, 4'b0100); set_g(3, 2047, 1023, 4'b0100);
      run_frame(4'b0100, 17, 1'b0, 0, 0, 0, 0, 0);
      chk("last_prev_dir", 64'(ctrl_prev_dir), 64'd1);
      chk("last_ctrl_ghost_x", 64'(ctrl_ghost_x), 64'd2047);

      set_g(0, 2, 1, 4'b0001); set_g(1, 102, 50, 4'b0001);
      set_g(2, 2, 1, 4'b0001); set_g(3, 2047, 1023, 4'b0001);
      run_frame(4'b0001, 17, 1'b1, 0, 0, 0, 0, 5);
      repeat (25) @(negedge clk);
      chk("overrun_sticky", 64'(overrun), 64'd1);
      chk("busy_load_ignored", 64'(ghost_x_flat[32:22]), 64'd2);

      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_overrun", 64'(overrun), 64'd0);
      chk("async_rst_x_flat", 64'(ghost_x_flat), 64'd0);
      chk("async_rst_y_flat", 64'(ghost_y_flat), 64'd0);
      chk("async_rst_ctrl", 64'({ctrl_ghost_x, ctrl_pac_x, ctrl_prev_dir}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("after_rst_idle", 64'({busy, frame_done}), 64'd0);

      set_g(0, 0, 1, 4'b0100); set_g(1, 0, 1, 4'b0100);
      set_g(2, 0, 1, 4'b0100); set_g(3, 0, 1, 4'b0100);
      run_frame(4'b0100, 17, 1'b0, 0, 0, 0, 0, 0);

`ifdef GHOST_FREEZE_EN
      do_load(0, 10, 10); do_load(1, 20, 20);
      do_load(2, 30, 30); do_load(3, 40, 40);
      freeze_mask = 4'b0101;
      saw_frozen = 1'b0;
      set_g(0, 10, 10, 4'b0100); set_g(1, 21, 20, 4'b0001);
      set_g(2, 30, 30, 4'b0100); set_g(3, 41, 40, 4'b0001);
      run_frame(4'b0001, 11, 1'b0, 0, 0, 0, 0, 0);
      chk("frozen_never_presented", 64'(saw_frozen), 64'd0);
      freeze_mask = 4'b0000;
`endif

      repeat (5) @(negedge clk);
      chk("pending_expectations", 64'(q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
      $fatal(1, "timeout");
   end
endmodule
